// File: rtl/shift_sin_pout_pkg.sv
// Shared constants for the serial-in / parallel-out receiver and its
// companion parallel-load serial-out transmitter.
package shift_sin_pout_pkg;

  localparam int DEF_WIDTH = 8;

  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/shift_sin_pout_if.sv
// Serial input / parallel output bundle between the receiver and its
// producer/consumer.
interface shift_sin_pout_if
  import shift_sin_pout_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             select;
  logic             sin;
  logic             ack;
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             overrun;
  logic             busy;

  modport master (
    output select, sin, ack,
    input  data, valid, overrun, busy
  );

  modport slave (
    input  select, sin, ack,
    output data, valid, overrun, busy
  );

endinterface

// File: rtl/shift_sin_pout.sv
// Serial-in, parallel-out receiver: MSB-first words are assembled while
// select is high and handed over with a valid/ack handshake.
module shift_sin_pout
  import shift_sin_pout_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input logic             clk,
  input logic             reset,
  shift_sin_pout_if.slave bus
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] shift;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             overrun;

  logic             complete;
  logic             accept;
  logic [WIDTH-1:0] next_word;

  always_comb begin
    next_word = {shift[WIDTH-2:0], bus.sin};
    complete  = bus.select && (cnt == LAST);
    // A finished word is only taken if the holding register is free or
    // being released on this very edge.
    accept    = complete && (!valid || bus.ack);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      shift   <= '0;
      cnt     <= '0;
      data    <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (!bus.select) begin
        cnt <= '0;
      end else if (complete) begin
        cnt <= '0;
      end else begin
        cnt   <= cnt + CNT_W'(1);
        shift <= next_word;
      end

      if (accept) begin
        data    <= next_word;
        valid   <= 1'b1;
        overrun <= 1'b0;
      end else if (complete) begin
        overrun <= 1'b1;
      end else if (bus.ack) begin
        valid   <= 1'b0;
        overrun <= 1'b0;
      end
    end
  end

  assign bus.data    = data;
  assign bus.valid   = valid;
  assign bus.overrun = overrun;
  assign bus.busy    = (cnt != '0);

endmodule

// File: tb/tb_shift_sin_pout.sv
// Directed bench for shift_sin_pout with a queue-based scoreboard on the
// delivered words.
module tb_shift_sin_pout;

  logic clk;
  logic reset;

  shift_sin_pout_if #(.WIDTH(8)) bus ();

  shift_sin_pout #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic       last_valid;
  logic       last_ack;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Shifts one word MSB first; ack is raised only on bit index ack_bit.
  task automatic shift_word(input logic [7:0] w, input int ack_bit);
    for (int i = 0; i < 8; i++) begin
      bus.select = 1'b1;
      bus.sin    = w[7-i];
      bus.ack    = (i == ack_bit);
      tick();
    end
    bus.ack = 1'b0;
  endtask

  task automatic idle_ack();
    bus.select = 1'b0;
    bus.sin    = 1'b0;
    bus.ack    = 1'b1;
    tick();
    bus.ack    = 1'b0;
  endtask

  // Monitor: a new word is presented when valid rises, or when valid stays
  // high across an edge on which the previous word was acknowledged.
  initial begin
    last_valid = 1'b0;
    last_ack   = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset && bus.valid && (!last_valid || last_ack)) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_word", {24'h0, bus.data}, 32'hFFFF_FFFF);
        end else begin
          check("sb_data", {24'h0, bus.data}, {24'h0, exp_q.pop_front()});
        end
      end
      last_valid = reset ? 1'b0 : bus.valid;
      last_ack   = bus.ack;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset      = 1'b1;
    bus.select = 1'b0;
    bus.sin    = 1'b0;
    bus.ack    = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    check("rst_data",    {24'h0, bus.data}, 32'h0);
    check("rst_valid",   {31'h0, bus.valid}, 32'h0);
    check("rst_overrun", {31'h0, bus.overrun}, 32'h0);
    check("rst_busy",    {31'h0, bus.busy}, 32'h0);

    // Single word A5
    exp_q.push_back(8'hA5);
    shift_word(8'hA5, -1);
    check("a5_valid",   {31'h0, bus.valid}, 32'h1);
    check("a5_overrun", {31'h0, bus.overrun}, 32'h0);
    check("a5_busy",    {31'h0, bus.busy}, 32'h0);
    idle_ack();
    check("a5_ack_valid", {31'h0, bus.valid}, 32'h0);

    // Overrun: 81 is dropped while 3C is unacknowledged
    exp_q.push_back(8'h3C);
    shift_word(8'h3C, -1);
    shift_word(8'h81, -1);
    check("ovr_data",    {24'h0, bus.data}, 32'h3C);
    check("ovr_valid",   {31'h0, bus.valid}, 32'h1);
    check("ovr_overrun", {31'h0, bus.overrun}, 32'h1);
    idle_ack();
    check("ovr_ack_valid",   {31'h0, bus.valid}, 32'h0);
    check("ovr_ack_overrun", {31'h0, bus.overrun}, 32'h0);

    // Ack coinciding with the completing edge of the next word
    exp_q.push_back(8'h0F);
    exp_q.push_back(8'hF0);
    shift_word(8'h0F, -1);
    shift_word(8'hF0, 7);
    check("ackc_data",    {24'h0, bus.data}, 32'hF0);
    check("ackc_valid",   {31'h0, bus.valid}, 32'h1);
    check("ackc_overrun", {31'h0, bus.overrun}, 32'h0);
    idle_ack();

    // Partial word aborted by select low
    for (int i = 0; i < 3; i++) begin
      bus.select = 1'b1;
      bus.sin    = 1'b1;
      tick();
    end
    check("abort_busy_mid", {31'h0, bus.busy}, 32'h1);
    bus.select = 1'b0;
    tick();
    check("abort_busy_low", {31'h0, bus.busy}, 32'h0);
    exp_q.push_back(8'h55);
    shift_word(8'h55, -1);
    check("abort_data",  {24'h0, bus.data}, 32'h55);
    check("abort_valid", {31'h0, bus.valid}, 32'h1);
    idle_ack();

    // Reset mid-word with a held word present
    exp_q.push_back(8'h77);
    shift_word(8'h77, -1);
    for (int i = 0; i < 5; i++) begin
      bus.select = 1'b1;
      bus.sin    = 1'b1;
      tick();
    end
    reset      = 1'b1;
    bus.select = 1'b1;
    bus.sin    = 1'b1;
    bus.ack    = 1'b0;
    tick();
    reset      = 1'b0;
    bus.select = 1'b0;
    check("mrst_data",    {24'h0, bus.data}, 32'h0);
    check("mrst_valid",   {31'h0, bus.valid}, 32'h0);
    check("mrst_overrun", {31'h0, bus.overrun}, 32'h0);
    check("mrst_busy",    {31'h0, bus.busy}, 32'h0);
    exp_q.push_back(8'h12);
    shift_word(8'h12, -1);
    check("mrst_new_data",  {24'h0, bus.data}, 32'h12);
    check("mrst_new_valid", {31'h0, bus.valid}, 32'h1);
    idle_ack();

    // Back-to-back words with continuous select
    exp_q.push_back(8'hC3);
    exp_q.push_back(8'h5A);
    shift_word(8'hC3, -1);
    check("b2b_first_data", {24'h0, bus.data}, 32'hC3);
    shift_word(8'h5A, 2);
    check("b2b_data",    {24'h0, bus.data}, 32'h5A);
    check("b2b_valid",   {31'h0, bus.valid}, 32'h1);
    check("b2b_overrun", {31'h0, bus.overrun}, 32'h0);
    idle_ack();

    tick();
    tick();
    check("sb_drained", exp_q.size(), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
